// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: stalls, flushes, redirect and halt sequencing.
// Also tracks sticky halt status and a saturating stall-cycle count.
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        br_taken,
    input  logic        mem_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MEMWAIT, REDIRECT, HALT} state_t;

    state_t     state, nxt;
    logic [4:0] en;
    logic [3:0] fl;
    logic       memop, lduse;

    assign memop = mem_dREN | mem_dWEN;
    assign lduse = ex_dREN && (ex_rt != 5'd0)
                 && ((ex_rt == id_rs) || (ex_rt == id_rt));

    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en;
    assign {ifid_flush, idex_flush, exmem_flush, memwb_flush} = fl;

    always_comb begin
        nxt = state;
        en  = 5'b00000;
        fl  = 4'b0000;
        unique case (state)
            RUN, REDIRECT: begin
                // halt and data miss outrank everything, even a pending redirect
                if (mem_halt) begin
                    en  = 5'b00001;
                    nxt = HALT;
                end else if (memop && !dhit) begin
                    fl  = 4'b0001;
                    nxt = MEMWAIT;
                end else if (state == REDIRECT) begin
                    en = {ihit, 4'b1111};
                    fl = {!ihit, 3'b000};
                    if (ihit) nxt = RUN;
                end else if (br_taken) begin
                    en  = 5'b11111;
                    fl  = 4'b1110;
                    nxt = REDIRECT;
                end else if (lduse) begin
                    en = 5'b00111;
                    fl = 4'b0100;
                end else if (!ihit) begin
                    en = 5'b01111;
                    fl = 4'b1000;
                end else begin
                    en = 5'b11111;
                end
            end
            MEMWAIT: begin
                if (dhit) begin
                    en  = {ihit, 4'b1111};
                    fl  = {!ihit, 3'b000};
                    nxt = RUN;
                end else begin
                    fl = 4'b0001;
                end
            end
            HALT: nxt = HALT;
            default: nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= RUN;
            halted    <= 1'b0;
            stall_cnt <= 16'd0;
        end else begin
            state <= nxt;
            if (nxt == HALT) halted <= 1'b1;
            if (!pc_en && state != HALT && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table plus multi-cycle sequences.
// Output vector order: pc,ifid,idex,exmem,memwb en; ifid,idex,exmem,memwb flush.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, br_taken, mem_halt;
    logic [4:0]  ex_rt, id_rs, id_rt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [8:0]  outs;

    int n_chk = 0;
    int n_pass = 0;

    localparam logic [8:0] FULL  = 9'h1FF;
    localparam logic [8:0] MIDX  = 9'b110111111;
    localparam logic [8:0] MIFD  = 9'b101111111;
    localparam logic [8:0] ALL1  = 9'b111110000;
    localparam logic [8:0] LU    = 9'b000110100;
    localparam logic [8:0] IMISS = 9'b001111000;
    localparam logic [8:0] BR    = 9'b111111110;
    localparam logic [8:0] MISS  = 9'b000000001;
    localparam logic [8:0] HLT   = 9'b000010000;
    localparam logic [8:0] NONE  = 9'b000000000;

    typedef struct {
        logic [6:0]  c;
        logic [4:0]  a, b, d;
        logic [8:0]  e, m;
        logic [15:0] s;
        logic        h;
    } vec_t;

    vec_t vq[$];

    pipeline_ctrl dut (
        .CLK(CLK), .nRST(nRST),
        .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .ex_dREN(ex_dREN), .ex_rt(ex_rt),
        .id_rs(id_rs), .id_rt(id_rt),
        .br_taken(br_taken), .mem_halt(mem_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, memwb_flush};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic chkm(input string nm, input logic [8:0] act,
                        input logic [8:0] exp, input logic [8:0] m);
        n_chk++;
        if (((act ^ exp) & m) === 9'd0) n_pass++;
        else $display("FAIL %s: got %b want %b mask %b", nm, act, exp, m);
    endtask

    // c = {ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, br_taken, mem_halt}
    task automatic drive(input logic [6:0] c, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d);
        {ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, br_taken, mem_halt} = c;
        ex_rt = a;
        id_rs = b;
        id_rt = d;
    endtask

    task automatic addv(input logic [6:0] c, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] d,
                        input logic [8:0] e, input logic [8:0] m,
                        input logic [15:0] s, input logic h);
        vec_t v;
        v.c = c; v.a = a; v.b = b; v.d = d;
        v.e = e; v.m = m; v.s = s; v.h = h;
        vq.push_back(v);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rst_pulse();
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
    endtask

    logic [6:0] hpat[4];

    initial begin
        addv(7'b1000000, 0, 0, 0, ALL1,  FULL, 16'd0, 1'b0);
        addv(7'b1000100, 5, 5, 0, LU,    MIDX, 16'd1, 1'b0);
        addv(7'b1000100, 7, 3, 7, LU,    MIDX, 16'd1, 1'b0);
        addv(7'b1000100, 0, 0, 0, ALL1,  FULL, 16'd0, 1'b0);
        addv(7'b1000000, 5, 5, 5, ALL1,  FULL, 16'd0, 1'b0);
        addv(7'b0000000, 0, 0, 0, IMISS, MIFD, 16'd1, 1'b0);
        addv(7'b0000100, 5, 5, 0, LU,    MIDX, 16'd1, 1'b0);
        addv(7'b1000010, 0, 0, 0, BR,    FULL, 16'd0, 1'b0);
        addv(7'b0000010, 0, 0, 0, BR,    FULL, 16'd0, 1'b0);
        addv(7'b1010000, 0, 0, 0, MISS,  FULL, 16'd1, 1'b0);
        addv(7'b1001010, 0, 0, 0, MISS,  FULL, 16'd1, 1'b0);
        addv(7'b1110000, 0, 0, 0, ALL1,  FULL, 16'd0, 1'b0);
        addv(7'b1010011, 0, 0, 0, HLT,   FULL, 16'd1, 1'b1);
        addv(7'b1010100, 5, 5, 0, MISS,  FULL, 16'd1, 1'b0);
        addv(7'b1101010, 0, 0, 0, BR,    FULL, 16'd0, 1'b0);

        drive(7'b1000000, 0, 0, 0);
        #12;
        chk("reset halted", {31'd0, halted}, 32'd0);
        chk("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chkm("reset run decode", outs, ALL1, FULL);
        nRST = 1'b1;

        foreach (vq[i]) begin
            tick();
            rst_pulse();
            drive(vq[i].c, vq[i].a, vq[i].b, vq[i].d);
            #1;
            chkm($sformatf("vec%0d outs", i), outs, vq[i].e, vq[i].m);
            tick();
            chk($sformatf("vec%0d stall_cnt", i), {16'd0, stall_cnt},
                {16'd0, vq[i].s});
            chk($sformatf("vec%0d halted", i), {31'd0, halted},
                {31'd0, vq[i].h});
        end

        // data miss held for three cycles
        tick();
        rst_pulse();
        drive(7'b1010000, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chkm($sformatf("miss wait%0d", i), outs, MISS, FULL);
            tick();
        end
        drive(7'b1110000, 0, 0, 0);
        #1;
        chkm("miss done", outs, ALL1, FULL);
        tick();
        drive(7'b0000000, 0, 0, 0);
        #1;
        chkm("miss back run", outs, IMISS, MIFD);
        chk("miss stall_cnt", {16'd0, stall_cnt}, 32'd3);

        // branch followed by two fetch misses
        tick();
        rst_pulse();
        drive(7'b1000010, 0, 0, 0);
        #1;
        chkm("br flush", outs, BR, FULL);
        tick();
        drive(7'b0000010, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            chkm($sformatf("redir wait%0d", i), outs, IMISS, MIFD);
            tick();
        end
        drive(7'b1000010, 0, 0, 0);
        #1;
        chkm("redir done", outs, ALL1, FULL);
        tick();
        #1;
        chkm("redir back run", outs, BR, FULL);
        chk("redir stall_cnt", {16'd0, stall_cnt}, 32'd2);

        // halt wins over branch, then everything is frozen
        tick();
        rst_pulse();
        drive(7'b1000011, 0, 0, 0);
        #1;
        chkm("halt entry", outs, HLT, FULL);
        chk("halt pre halted", {31'd0, halted}, 32'd0);
        tick();
        chk("halt halted", {31'd0, halted}, 32'd1);
        hpat[0] = 7'b1000000;
        hpat[1] = 7'b0010100;
        hpat[2] = 7'b1010000;
        hpat[3] = 7'b0000010;
        for (int i = 0; i < 4; i++) begin
            drive(hpat[i], 5, 5, 0);
            #1;
            chkm($sformatf("halt frozen%0d", i), outs, NONE, FULL);
            tick();
            chk($sformatf("halt sticky%0d", i), {31'd0, halted}, 32'd1);
        end
        chk("halt stall_cnt", {16'd0, stall_cnt}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("halt reset clears", {31'd0, halted}, 32'd0);
        nRST = 1'b1;

        // async reset in the middle of a data miss
        tick();
        rst_pulse();
        drive(7'b1010000, 0, 0, 0);
        tick();
        tick();
        chk("memwait stall_cnt", {16'd0, stall_cnt}, 32'd2);
        #1;
        nRST = 1'b0;
        #1;
        chk("async rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("async rst halted", {31'd0, halted}, 32'd0);
        drive(7'b1000000, 0, 0, 0);
        #1;
        chkm("async rst decode", outs, ALL1, FULL);
        tick();
        nRST = 1'b1;
        #1;
        chkm("post rst decode", outs, ALL1, FULL);
        tick();
        chkm("post rst run", outs, ALL1, FULL);
        chk("post rst stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // 70000 fetch-miss cycles saturate the counter
        tick();
        rst_pulse();
        drive(7'b0000000, 0, 0, 0);
        repeat (65534) tick();
        chk("sat fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
        tick();
        chk("sat ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
        repeat (4465) tick();
        chk("sat hold", {16'd0, stall_cnt}, 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: ports CLK and nRST.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- CLK  in  1  clock, rising edge
- nRST  in  1  async active-low reset
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- mem_dREN, mem_dWEN  in  1 each  load/store present in the MEM stage (EX/MEM outputs)
- ex_dREN  in  1  load present in the EX stage (ID/EX outputs)
- ex_rt  in  5  load destination register in EX
- id_rs, id_rt  in  5 each  source registers in ID (IF/ID decode)
- br_taken  in  1  branch/jump redirect resolved in MEM
- mem_halt  in  1  halt instruction in MEM
- pc_en  out  1  PC update enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  pipeline register flushes; flush overrides enable inside each register
- halted  out  1  core halted, sticky
- stall_cnt  out  16  saturating stall-cycle counter

Function
REQ-003 SHALL implement a registered FSM with states RUN, MEMWAIT, REDIRECT and HALT; all outputs except state, halted and stall_cnt are combinational from the state and inputs.
REQ-004 In RUN, SHALL evaluate these conditions in strict priority order; the first match applies:
- (a) mem_halt=1: memwb_en=1, all other enables 0, all flushes 0; next state HALT.
- (b) (mem_dREN|mem_dWEN)=1 and dhit=0: all enables 0, memwb_flush=1; next state MEMWAIT.
- (c) br_taken=1: all enables 1; ifid_flush=idex_flush=exmem_flush=1; pc_en=1 loads the target; next state REDIRECT.
- (d) load-use: ex_dREN=1, ex_rt!=0, and ex_rt equals id_rs or id_rt: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; stay in RUN.
- (e) ihit=0: pc_en=0, ifid_flush=1, idex_en=exmem_en=memwb_en=1; stay in RUN.
- (f) otherwise: all enables 1, all flushes 0.
REQ-005 In MEMWAIT with dhit=0, SHALL hold all enables at 0 and memwb_flush=1.
REQ-006 In MEMWAIT with dhit=1, SHALL set all enables to 1 and return to RUN; if ihit=0 in that cycle, pc_en=0 and ifid_flush=1.
REQ-007 In REDIRECT, SHALL set pc_en=ihit and ifid_flush=1 while ihit=0 (idex/exmem/memwb enables 1), and return to RUN on the first cycle ihit=1, with all enables 1 in that cycle.
REQ-008 In REDIRECT, SHALL apply mem_halt and MEMWAIT entry with the priority of REQ-004(a)(b).
REQ-009 In HALT, SHALL hold all enables and flushes at 0 and halted=1; the only exit is reset.
REQ-010 Register halted SHALL be set on the edge that enters HALT.
REQ-011 stall_cnt SHALL increment by 1 on every edge where pc_en=0 and the state is not HALT, and SHALL saturate at 16'hFFFF.
REQ-012 Load-use detection SHALL ignore register 0: ex_rt=0 never stalls.
REQ-013 Simultaneous br_taken and a pending data miss SHALL resolve as a miss first; br_taken is re-evaluated after MEMWAIT exits to RUN.

Reset
REQ-014 While nRST=0: state=RUN, halted=0, stall_cnt=0, independent of CLK.
REQ-015 Reset asserted mid-MEMWAIT or mid-REDIRECT SHALL abandon the operation; the first cycle after release behaves per REQ-004.
REQ-016 Combinational outputs during reset SHALL follow RUN-state decoding of the current inputs.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Load-use: ex_dREN=1, ex_rt=5, id_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1. Same stimulus with ex_rt=0 -> all enables 1.
- Data miss: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles of all enables 0 with memwb_flush=1, then one cycle of all enables 1; stall_cnt=3; state back in RUN.
- Branch with fetch miss: br_taken=1 -> three flushes asserted one cycle; ihit=0 for 2 cycles -> pc_en=0, ifid_flush=1; ihit=1 -> RUN.
- Halt: mem_halt=1 together with br_taken=1 -> memwb_en=1 only; halted=1 next edge; all outputs 0 afterwards regardless of inputs.
- Saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF and holds.
- Async reset mid-MEMWAIT: nRST low between edges -> halted=0 and stall_cnt=0 immediately; with dhit=0 and no memory op after release, all enables 1.
